// File: rtl/gpu_def.sv
// Shared GPU definitions: memory command codes, XY-counter selects,
// sub-state-machine index map and the dispatcher state encoding.
package gpu_def;

    localparam logic [2:0] MEM_CMD_NONE    = 3'd0;
    localparam logic [2:0] MEM_CMD_RDBURST = 3'd1;
    localparam logic [2:0] MEM_CMD_WRBURST = 3'd2;

    localparam logic [2:0] X_ASIS = 3'd0;
    localparam logic [2:0] Y_ASIS = 3'd0;

    localparam logic [1:0] SM_IDX_FILL   = 2'd0;
    localparam logic [1:0] SM_IDX_COPYVV = 2'd1;
    localparam logic [1:0] SM_IDX_COPYCV = 2'd2;
    localparam logic [1:0] SM_IDX_COPYVC = 2'd3;

    typedef enum logic [1:0] {
        DSP_IDLE,
        DSP_DRAIN,
        DSP_LAUNCH,
        DSP_RUN
    } dispState_t;

    // Primitives that read VRAM must wait for earlier writes to retire.
    function automatic logic readsVram(input logic [1:0] cmdType);
        return (cmdType == SM_IDX_COPYVV) || (cmdType == SM_IDX_COPYVC);
    endfunction

endpackage

// File: rtl/gpu_pend_counter.sv
// Outstanding memory-burst counter: saturating up/down with a sticky
// underflow flag for retires that arrive when nothing is in flight.
module gpu_pend_counter #(
    parameter int PEND_W = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero,
    output logic o_full,
    output logic o_err
);

    logic [PEND_W-1:0] count;
    logic              decOk;

    assign o_zero = (count == '0);
    assign o_full = (count == '1);
    assign decOk  = i_dec & ~o_zero;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
            o_err <= 1'b0;
        end else begin
            if (i_dec && o_zero)
                o_err <= 1'b1;
            // A simultaneous issue and retire cancel out.
            if (i_inc && !decOk && !o_full)
                count <= count + 1'b1;
            else if (decOk && !i_inc)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/gpu_sm_dispatch.sv
// Primitive dispatcher: launches one sub-SM per command, routes its controls
// onto the shared datapath and holds VRAM readers until writes have drained.
import gpu_def::*;

module gpu_sm_dispatch #(
    parameter int PEND_W = 4,
    parameter int NREQ   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmdValid,
    input  logic [1:0]        i_cmdType,
    output logic              o_cmdReady,
    output logic [NREQ-1:0]   o_activate,
    input  logic [NREQ-1:0]   i_smActive,
    input  logic [NREQ-1:0]   i_smInactiveNext,
    input  logic [3*NREQ-1:0] i_smMemCmd,
    input  logic [NREQ-1:0]   i_smLoadNext,
    input  logic [3*NREQ-1:0] i_smSelNextX,
    input  logic [3*NREQ-1:0] i_smSelNextY,
    input  logic [NREQ-1:0]   i_smResetX,
    input  logic [NREQ-1:0]   i_smIncX,
    input  logic              i_commandFIFOaccept,
    output logic [NREQ-1:0]   o_smFIFOaccept,
    input  logic              i_memCmdDone,
    output logic [2:0]        o_memoryCommand,
    output logic              o_loadNext,
    output logic [2:0]        o_selNextX,
    output logic [2:0]        o_selNextY,
    output logic              o_resetXCounter,
    output logic              o_incrementXCounter,
    output logic              o_busy,
    output logic              o_gpuIdle,
    output logic              o_pendErr
);

    dispState_t state;
    logic [1:0] sel;
    logic       pendZero;
    logic       pendFull;
    logic [2:0] smMemCmd [NREQ];
    logic [2:0] smSelX   [NREQ];
    logic [2:0] smSelY   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign smMemCmd[i] = i_smMemCmd[3*i +: 3];
        assign smSelX[i]   = i_smSelNextX[3*i +: 3];
        assign smSelY[i]   = i_smSelNextY[3*i +: 3];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= DSP_IDLE;
            sel   <= '0;
        end else begin
            case (state)
                DSP_IDLE: begin
                    if (i_cmdValid) begin
                        sel   <= i_cmdType;
                        state <= (readsVram(i_cmdType) && !pendZero) ? DSP_DRAIN : DSP_LAUNCH;
                    end
                end
                DSP_DRAIN:  if (pendZero) state <= DSP_LAUNCH;
                DSP_LAUNCH: state <= DSP_RUN;
                DSP_RUN:    if (i_smInactiveNext[sel]) state <= DSP_IDLE;
                default:    state <= DSP_IDLE;
            endcase
        end
    end

    assign o_cmdReady = (state == DSP_IDLE);
    assign o_busy     = (state != DSP_IDLE);
    assign o_gpuIdle  = (state == DSP_IDLE) && pendZero;
    assign o_activate = (state == DSP_LAUNCH) ? (NREQ'(1) << sel) : '0;

    // Only the launched sub-SM reaches the datapath, and only while running.
    always_comb begin
        o_memoryCommand     = MEM_CMD_NONE;
        o_loadNext          = 1'b0;
        o_selNextX          = X_ASIS;
        o_selNextY          = Y_ASIS;
        o_resetXCounter     = 1'b0;
        o_incrementXCounter = 1'b0;
        o_smFIFOaccept      = '0;
        if (state == DSP_RUN) begin
            o_memoryCommand     = smMemCmd[sel];
            o_loadNext          = i_smLoadNext[sel];
            o_selNextX          = smSelX[sel];
            o_selNextY          = smSelY[sel];
            o_resetXCounter     = i_smResetX[sel];
            o_incrementXCounter = i_smIncX[sel];
            o_smFIFOaccept[sel] = i_commandFIFOaccept & ~pendFull;
        end
    end

    gpu_pend_counter #(
        .PEND_W (PEND_W)
    ) u_pend (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (o_memoryCommand != MEM_CMD_NONE),
        .i_dec  (i_memCmdDone),
        .o_zero (pendZero),
        .o_full (pendFull),
        .o_err  (o_pendErr)
    );

    onlySelActive: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_smActive & ~(NREQ'(1) << sel)) == '0);

endmodule

// File: doc/gpu_sm_dispatch.md
Name: gpu_sm_dispatch

Overview:
- Front-end scheduler for the GPU primitive sub-state-machines: FILL, COPY_VV, COPY_CV and COPY_VC.
- Accepts one decoded primitive command at a time and launches the matching sub-SM with a one-cycle activate pulse.
- Multiplexes that sub-SM's control outputs onto the shared XY-counter / memory-command datapath and gates the command-FIFO accept back to it.
- Tracks outstanding memory bursts so that VRAM-reading primitives start only after earlier writes have drained (read-after-write hazard).

Parameters:
- PEND_W, 4, width of the outstanding-burst counter; maximum in flight is 2^PEND_W-1.
- NREQ, 4, number of sub-SMs; fixed at 4, index map given in the package.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset (see Behaviour)
- i_cmdValid  in  1  decoded primitive is available
- i_cmdType  in  2  0=FILL, 1=COPY_VV, 2=COPY_CV, 3=COPY_VC
- o_cmdReady  out  1  command consumed this cycle (i_cmdValid & o_cmdReady)
- o_activate  out  4  one-hot activate pulse, indexed by cmdType
- i_smActive  in  4  per-sub-SM o_active
- i_smInactiveNext  in  4  per-sub-SM o_*InactiveNextCycle
- i_smMemCmd  in  12  3 bits per sub-SM, memory command
- i_smLoadNext  in  4  per-sub-SM loadNext
- i_smSelNextX  in  12  3 bits per sub-SM
- i_smSelNextY  in  12  3 bits per sub-SM
- i_smResetX  in  4  per-sub-SM resetXCounter
- i_smIncX  in  4  per-sub-SM incrementXCounter
- i_commandFIFOaccept  in  1  memory command FIFO can take a command
- o_smFIFOaccept  out  4  gated accept, routed to the selected sub-SM only
- i_memCmdDone  in  1  one burst retired by the memory side
- o_memoryCommand  out  3  muxed memory command
- o_loadNext  out  1  muxed
- o_selNextX  out  3  muxed
- o_selNextY  out  3  muxed
- o_resetXCounter  out  1  muxed
- o_incrementXCounter  out  1  muxed
- o_busy  out  1  state != DSP_IDLE
- o_gpuIdle  out  1  state == DSP_IDLE and pending == 0
- o_pendErr  out  1  sticky: retire received while pending == 0

Behaviour:
- Reset i_rst is synchronous and active-high; the clock is i_clk.
- Reset state: state=DSP_IDLE, sel=0, pending=0, o_pendErr=0, o_activate=0.
- After reset, all muxed outputs take their defaults: MEM_CMD_NONE, X_ASIS, Y_ASIS, all other controls 0.
- Reset mid-operation aborts immediately. Sub-SMs share i_rst and are not otherwise cancelled.

State machine (registered state, combinational outputs):
- DSP_IDLE:
  - o_cmdReady=1.
  - On i_cmdValid, latch sel=i_cmdType.
  - If cmdType is COPY_VV or COPY_VC and pending!=0 (before this cycle's update), go to DSP_DRAIN; otherwise go to DSP_LAUNCH.
- DSP_DRAIN: hold until pending==0, then go to DSP_LAUNCH. No timeout.
- DSP_LAUNCH: o_activate[sel]=1 for exactly one cycle, then go to DSP_RUN.
- DSP_RUN:
  - All muxed outputs are driven from sub-SM[sel].
  - o_smFIFOaccept[sel] = i_commandFIFOaccept & (pending != 2^PEND_W-1). All other accept bits are 0.
  - When i_smInactiveNext[sel]=1, go to DSP_IDLE; that cycle's muxed outputs are still passed through.
  - A command held valid is accepted no earlier than the cycle after the return to DSP_IDLE.
- Outside DSP_RUN: muxed outputs take their defaults and o_smFIFOaccept=0.

Latency:
- Command accept to activate pulse: 1 cycle without drain, or 1 + drain cycles with drain.
- Sub-SM outputs pass through combinationally, with zero latency.

Pending counter:
- inc = (o_memoryCommand != MEM_CMD_NONE).
- dec = i_memCmdDone & (pending != 0).
- inc and dec in the same cycle leave the counter unchanged.
- i_memCmdDone with pending==0 sets o_pendErr; the counter stays 0.
- The counter never wraps: accept gating prevents increments when full.

Other rules:
- Activity from non-selected sub-SMs is ignored. Assertion: only sub-SM[sel] may have i_smActive=1.

Decomposition:
- Package gpu_def.sv: existing MEM_CMD_*, X_ASIS and Y_ASIS; new dispState_t enum (DSP_IDLE, DSP_DRAIN, DSP_LAUNCH, DSP_RUN).
- Package gpu_def.sv: new SM_IDX_FILL=0, SM_IDX_COPYVV=1, SM_IDX_COPYCV=2, SM_IDX_COPYVC=3.
- One sub-module, gpu_pend_counter: saturating up/down counter exposing o_zero, o_full and the sticky o_err.

Test Plan:
- Idle start:
  - Stimulus: pending=0, cmdType=1 valid at cycle 0.
  - Required: o_cmdReady=1 at cycle 0, o_activate=4'b0010 at cycle 1 only, outputs mux sub-SM1 from cycle 2.
  - Required: i_smInactiveNext[1] at cycle 10 → o_busy=0 at cycle 11.
- Drain:
  - Stimulus: a FILL issues 3 WRBURSTs and ends; COPY_VV is then requested; i_memCmdDone is pulsed 3 times, 5 cycles apart.
  - Required: activate[1] fires exactly 2 cycles after the 3rd retire (1 cycle DRAIN exit, 1 cycle LAUNCH).
  - Required: COPY_CV under the same condition launches without drain.
- Saturation (PEND_W=2):
  - Stimulus: selected sub-SM issues 3 bursts with no retires.
  - Required: o_smFIFOaccept[sel]=0 while pending=3; one retire restores it the following cycle.
- Simultaneous inc/dec:
  - Stimulus: pending=2, RDBURST issued with i_memCmdDone in the same cycle.
  - Required: pending stays 2.
  - Stimulus: i_memCmdDone at pending=0.
  - Required: o_pendErr=1 and stays set until reset.
- Isolation:
  - Stimulus: sel=3; sub-SM0 drives a WRBURST and loadNext=1.
  - Required: o_memoryCommand=MEM_CMD_NONE is not caused by sub-SM0, o_loadNext follows sub-SM3 only, o_smFIFOaccept[0]=0.
- Reset mid-run:
  - Stimulus: i_rst in DSP_RUN with pending=2.
  - Required: next cycle state=DSP_IDLE, pending=0, o_gpuIdle=1, o_memoryCommand=MEM_CMD_NONE.
